// File: rtl/flag_meter_pkg.sv
// Shared definitions for the flag interval meter: FSM encoding,
// record layout (sat bit above the interval) and default widths.
package flag_meter_pkg;

    localparam int CNT_W_DEF = 8;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MEASURE = 1'b1;

    // Record = {sat, interval[cnt_w-1:0]}
    function automatic int rec_w(input int cnt_w);
        return cnt_w + 1;
    endfunction

endpackage

// File: rtl/flag_meter_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered
// one-cycle overflow pulse when a push is dropped.
module flag_meter_fifo #(
    parameter  int W     = 9,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  level,
    output logic         overflow
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push & ~do_push;
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/flag_interval_meter.sv
// Measures clk cycles between flag pulses and queues {sat, interval} records.
// Define FLAG_METER_MINMAX_EN to add min_interval/max_interval outputs.
module flag_interval_meter
    import flag_meter_pkg::*;
#(
    parameter  int CNT_W = CNT_W_DEF,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_interval,
    output logic             out_sat,
    output logic             overflow,
    output logic [AW:0]      fifo_level
`ifdef FLAG_METER_MINMAX_EN
    ,
    output logic [CNT_W-1:0] min_interval,
    output logic [CNT_W-1:0] max_interval
`endif
);

    localparam int RW = rec_w(CNT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             rec_push;
    logic [RW-1:0]    rec;
    logic [RW-1:0]    head;
    logic             fifo_empty;
    logic             unused_full;

    assign rec_push = (state == ST_MEASURE) & enable & flag;
    assign rec      = {cnt == CNT_MAX, cnt};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (enable && flag) begin
                        state <= ST_MEASURE;
                        cnt   <= CNT_W'(1);
                    end
                end
                ST_MEASURE: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (flag) begin
                        cnt <= CNT_W'(1);
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    flag_meter_fifo #(
        .W     (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rec_push),
        .din      (rec),
        .pop      (out_ready),
        .dout     (head),
        .full     (unused_full),
        .empty    (fifo_empty),
        .level    (fifo_level),
        .overflow (overflow)
    );

    // Head is gated so every output reads 0 while nothing is stored
    assign out_valid    = ~fifo_empty;
    assign out_interval = fifo_empty ? '0 : head[CNT_W-1:0];
    assign out_sat      = fifo_empty ? 1'b0 : head[CNT_W];

`ifdef FLAG_METER_MINMAX_EN
    // Tracks every generated record, including ones the FIFO drops
    always_ff @(posedge clk) begin
        if (!rst) begin
            min_interval <= CNT_MAX;
            max_interval <= '0;
        end else if (rec_push) begin
            if (cnt < min_interval) min_interval <= cnt;
            if (cnt > max_interval) max_interval <= cnt;
        end
    end
`endif

endmodule

// File: tb/tb_flag_interval_meter.sv
// Self-checking bench for flag_interval_meter (CNT_W=8, DEPTH=4),
// directed scenarios followed by random traffic against a timestamp model.
module tb_flag_interval_meter;

    localparam int CNT_W = 8;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);
    localparam int MAXV  = 255;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             enable = 1'b0;
    logic             flag = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [CNT_W-1:0] out_interval;
    logic             out_sat;
    logic             overflow;
    logic [AW:0]      fifo_level;
`ifdef FLAG_METER_MINMAX_EN
    logic [CNT_W-1:0] min_interval;
    logic [CNT_W-1:0] max_interval;
`endif

    flag_interval_meter #(
        .CNT_W (CNT_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .flag         (flag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_interval (out_interval),
        .out_sat      (out_sat),
        .overflow     (overflow),
        .fifo_level   (fifo_level)
`ifdef FLAG_METER_MINMAX_EN
        ,
        .min_interval (min_interval),
        .max_interval (max_interval)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: timestamps of flags and a bounded record queue
    int t = 0;
    bit have_last = 0;
    int last_t = 0;
    int q_iv[$];
    bit q_sat[$];
    bit m_ov = 0;
    int m_min = MAXV;
    int m_max = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        bit gen;
        int iv;
        bit sat;
        gen = 0;
        iv = 0;
        sat = 0;
        if (!rst) begin
            have_last = 0;
            q_iv.delete();
            q_sat.delete();
            m_ov = 0;
            m_min = MAXV;
            m_max = 0;
        end else begin
            if (enable && flag && have_last) begin
                gen = 1;
                sat = (t - last_t) >= MAXV;
                iv = sat ? MAXV : (t - last_t);
                if (iv < m_min) m_min = iv;
                if (iv > m_max) m_max = iv;
            end
            if (!enable) begin
                have_last = 0;
            end else if (flag) begin
                have_last = 1;
                last_t = t;
            end
            if (out_ready && q_iv.size() > 0) begin
                void'(q_iv.pop_front());
                void'(q_sat.pop_front());
            end
            m_ov = 0;
            if (gen) begin
                if (q_iv.size() < DEPTH) begin
                    q_iv.push_back(iv);
                    q_sat.push_back(sat);
                end else begin
                    m_ov = 1;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("valid", 32'(out_valid), 32'(q_iv.size() > 0));
        chk("level", 32'(fifo_level), 32'(q_iv.size()));
        chk("overflow", 32'(overflow), 32'(m_ov));
        if (q_iv.size() > 0) begin
            chk("interval", 32'(out_interval), 32'(q_iv[0]));
            chk("sat", 32'(out_sat), 32'(q_sat[0]));
        end
`ifdef FLAG_METER_MINMAX_EN
        chk("min", 32'(min_interval), 32'(m_min));
        chk("max", 32'(max_interval), 32'(m_max));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        t++;
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse();
        flag = 1'b1;
        tick();
        flag = 1'b0;
    endtask

    initial begin
        // Reset
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // Intervals 5 and 10
        enable = 1'b1;
        out_ready = 1'b1;
        pulse();
        chk("first_flag_norec", 32'(out_valid), 32'd0);
        idle(4);
        pulse();
        chk("iv5_valid", 32'(out_valid), 32'd1);
        chk("iv5", 32'(out_interval), 32'd5);
        chk("iv5_sat", 32'(out_sat), 32'd0);
        idle(9);
        pulse();
        chk("iv10", 32'(out_interval), 32'd10);
        chk("iv10_sat", 32'(out_sat), 32'd0);

        // Saturation
        idle(299);
        pulse();
        chk("sat_iv", 32'(out_interval), 32'd255);
        chk("sat_bit", 32'(out_sat), 32'd1);
        idle(2);

        // Fill and overflow
        enable = 1'b0;
        tick();
        enable = 1'b1;
        out_ready = 1'b0;
        pulse();
        for (int k = 0; k < 5; k++) begin
            idle(3);
            pulse();
        end
        chk("full_level", 32'(fifo_level), 32'd4);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        idle(1);
        chk("ovf_once", 32'(overflow), 32'd0);
        idle(2);
        out_ready = 1'b1;
        pulse();
        chk("push_pop_full", 32'(fifo_level), 32'd4);
        chk("push_pop_noovf", 32'(overflow), 32'd0);

        // Enable drop mid-interval
        out_ready = 1'b0;
        idle(2);
        enable = 1'b0;
        idle(3);
        enable = 1'b1;
        pulse();
        chk("reen_norec_lvl", 32'(fifo_level), 32'd4);
        chk("reen_norec_ovf", 32'(overflow), 32'd0);
        idle(5);
        pulse();
        chk("reen_rec_drop", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        idle(6);
        chk("drained", 32'(fifo_level), 32'd0);

`ifdef FLAG_METER_MINMAX_EN
        rst = 1'b0;
        tick();
        rst = 1'b1;
        pulse();
        idle(6);
        pulse();
        idle(2);
        pulse();
        idle(8);
        pulse();
        chk("minmax_min", 32'(min_interval), 32'd3);
        chk("minmax_max", 32'(max_interval), 32'd9);
        rst = 1'b0;
        tick();
        chk("minmax_rst_min", 32'(min_interval), 32'd255);
        chk("minmax_rst_max", 32'(max_interval), 32'd0);
        rst = 1'b1;
`endif

        // Random traffic, dense flags with occasional reset
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) != 0);
            enable = ($urandom_range(0, 15) != 0);
            flag = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) == 0);
            tick();
        end

        // Random traffic, sparse flags to reach saturation
        rst = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            enable = ($urandom_range(0, 999) != 0);
            flag = ($urandom_range(0, 199) == 0);
            out_ready = ($urandom_range(0, 1) == 0);
            tick();
        end
        flag = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
